rle_decoder: RTL and testbench
==============================

// Module: rle_decoder
// PURPOSE
// - Downstream stage of the run-length encoder: consumes the encoded byte stream and re-expands it to the original 7-bit symbol stream.
// - Encoded stream format:
//   - literal word: {1'b0, sym[6:0]}
//   - run: header word {1'b1, sym[6:0]} followed by count word cnt[7:0], meaning cnt copies of sym.
// - Valid/ready handshake on both sides; output stage is registered, so downstream stalls back-pressure the encoder.
// PARAMETERS
// - DATA_W  7  symbol width; encoded word width is DATA_W+1.
// - CNT_W   8  run-count width; must be <= DATA_W+1 (count word occupies the low CNT_W bits).
// PORTS
// - clock         in   1         single clock; all state updates on posedge.
// - reset         in   1         asynchronous, active-high reset.
// - in_valid      in   1         encoded word present on in_word.
// - in_ready      out  1         decoder accepts in_word this cycle (accept = in_valid & in_ready).
// - in_word       in   DATA_W+1  encoded word: literal, run header or count.
// - out_valid     out  1         out_data holds a decoded symbol.
// - out_ready     in   1         downstream takes out_data (take = out_valid & out_ready).
// - out_data      out  DATA_W    decoded symbol.
// - run_active    out  1         high while in GET_CNT or EXPAND.
// - err_zero_run  out  1         sticky: a count word of 0 was received.
// BEHAVIOUR
// - Reset (async, any state, mid-run included):
//   - state=IDLE; out_valid=0, out_data=0, run_active=0, err_zero_run=0; internal symbol/remaining regs=0.
//   - First edge after reset deassert behaves as IDLE.
// - slot_free = !out_valid | out_ready (output register empty or being taken this cycle).
// - FSM states: IDLE, GET_CNT, EXPAND.
// - IDLE:
//   - in_ready = slot_free.
//   - Accepted word with MSB=0 (literal): out_data<=word[DATA_W-1:0], out_valid<=1 next cycle; 1-cycle latency; stay IDLE.
//   - Accepted word with MSB=1 (header): sym_reg<=word[DATA_W-1:0]; ->GET_CNT; no output.
// - GET_CNT:
//   - in_ready = 1 (output register not touched; an earlier literal may still be draining).
//   - Count word accepted with cnt==0: err_zero_run<=1; ->IDLE; nothing emitted.
//   - Count word accepted with cnt!=0: remaining<=cnt; ->EXPAND.
// - EXPAND:
//   - in_ready = 0.
//   - Each cycle with slot_free: out_data<=sym_reg, out_valid<=1, remaining<=remaining-1.
//   - Emission where remaining==1: ->IDLE.
//   - First copy is visible 2 cycles after count accept; with out_ready held high, one copy per cycle, no bubbles.
// - Output hold: when out_valid & !out_ready, out_data and out_valid are held unchanged; no load in any state.
// - out_valid drops to 0 on a take with no new load in the same cycle.
// - IDLE literal after a run: when EXPAND returns to IDLE, in_ready follows slot_free that same cycle, so a literal can load on the next edge (back-to-back, no gap).
// - Count arithmetic:
//   - remaining is CNT_W bits, unsigned; max run = 2^CNT_W-1 (255); never wraps (decrement only while >=1).
//   - Count word bits above CNT_W are ignored.
// - run_active = (state != IDLE), combinational from state.
// - err_zero_run clears only on reset; decoding continues normally after the error.
// TESTING
// - Literals 0x05,0x7F,0x00 with in_valid held and out_ready=1 -> out_data 05,7F,00 on consecutive cycles; each 1 cycle after accept.
// - Header 0x83, count 0x04, out_ready=1 -> symbol 0x03 four times on consecutive cycles, first 2 cycles after count accept.
//   - in_ready=0 during EXPAND; run_active high from header accept until the last copy is loaded.
// - Run sym 0x11 cnt 3 with out_ready toggling 1,0,1,0... -> exactly three 0x11 takes; out_data stable while stalled.
// - Header 0x85, count 0x00 -> no output, err_zero_run=1 and stays 1; following literal 0x06 is decoded normally.
// - Run cnt 0xFF -> exactly 255 copies, then IDLE; no wrap to 0xFF.
// - Reset asserted mid-EXPAND (remaining=10) -> out_valid=0, run_active=0 immediately; next literal after release decodes correctly.

Source files
------------

// File: rtl/rle_decoder.sv
// Run-length decoder: expands literal words and {header, count} run pairs back into
// a stream of DATA_W-bit symbols behind a registered valid/ready output stage.
module rle_decoder #(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              run_active,
  output logic              err_zero_run
);

  typedef enum logic [1:0] {
    IDLE,
    GET_CNT,
    EXPAND
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] sym_reg;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  cnt_word;
  logic              slot_free;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              sym_load;
  logic              rem_load;
  logic              rem_dec;
  logic              err_set;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign cnt_word  = in_word[CNT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    load_data  = sym_reg;
    sym_load   = 1'b0;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = slot_free;
        if (accept) begin
          if (!in_word[DATA_W]) begin
            load      = 1'b1;
            load_data = in_word[DATA_W-1:0];
          end else begin
            sym_load   = 1'b1;
            state_next = GET_CNT;
          end
        end
      end
      // Output register is left alone here so a literal ahead of the header can drain.
      GET_CNT: begin
        in_ready = 1'b1;
        if (accept) begin
          if (cnt_word == '0) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end else begin
            rem_load   = 1'b1;
            state_next = EXPAND;
          end
        end
      end
      EXPAND: begin
        if (slot_free && remaining != '0) begin
          load    = 1'b1;
          rem_dec = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      sym_reg      <= '0;
      remaining    <= '0;
      err_zero_run <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (sym_load) begin
        sym_reg <= in_word[DATA_W-1:0];
      end
      if (rem_load) begin
        remaining <= cnt_word;
      end else if (rem_dec) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (err_set) begin
        err_zero_run <= 1'b1;
      end
    end
  end

  assign run_active = (state != IDLE);

endmodule

// File: tb/tb_rle_decoder.sv
// Testbench for rle_decoder: directed timing scenarios plus a randomized stream
// checked against an expected-symbol queue built from the encoded stream.
module tb_rle_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       run_active;
  logic       err_zero_run;

  int checks   = 0;
  int failures = 0;

  rle_decoder #(.DATA_W(7), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .run_active  (run_active),
    .err_zero_run(err_zero_run)
  );

  always #5 clock = ~clock;

  // Samples handshakes just before the edge, then returns 1 time unit after it.
  task automatic cycle(output bit acc, output bit tk, output logic [6:0] td, output bit stall);
    #1;
    acc   = in_valid && in_ready;
    tk    = out_valid && out_ready;
    td    = out_data;
    stall = out_valid && !out_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 7'h00) begin
      failures++;
      $display("FAIL reset_out actual=%b/%h expected=0/00", out_valid, out_data);
    end
    checks++;
    if (run_active !== 1'b0 || err_zero_run !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags actual=%b%b%b expected=001", run_active, err_zero_run, in_ready);
    end
  endtask

  task automatic test_literals();
    logic [6:0] lits [3];
    bit acc, tk, st;
    logic [6:0] td;
    lits = '{7'h05, 7'h7F, 7'h00};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_word = {1'b0, lits[i]};
      cycle(acc, tk, td, st);
      checks++;
      if (!acc || out_valid !== 1'b1 || out_data !== lits[i]) begin
        failures++;
        $display("FAIL literal%0d actual=acc%b v%b d%h expected=acc1 v1 d%h", i, acc, out_valid, out_data, lits[i]);
      end
    end
    in_valid = 1'b0;
    cycle(acc, tk, td, st);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL literal_drain actual=%b expected=0", out_valid);
    end
  endtask

  task automatic test_run();
    bit acc, tk, st;
    logic [6:0] td;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'h83;
    cycle(acc, tk, td, st);
    checks++;
    if (!acc || run_active !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_header actual=acc%b ra%b v%b expected=acc1 ra1 v0", acc, run_active, out_valid);
    end
    in_word = 8'h04;
    cycle(acc, tk, td, st);
    checks++;
    if (!acc || in_ready !== 1'b0 || out_valid !== 1'b0 || run_active !== 1'b1) begin
      failures++;
      $display("FAIL run_count actual=acc%b rdy%b v%b ra%b expected=acc1 rdy0 v0 ra1",
               acc, in_ready, out_valid, run_active);
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle(acc, tk, td, st);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 7'h03 || run_active !== (k < 4) || in_ready !== (k == 4)) begin
        failures++;
        $display("FAIL run_copy%0d actual=v%b d%h ra%b rdy%b expected=v1 d03 ra%b rdy%b",
                 k, out_valid, out_data, run_active, in_ready, k < 4, k == 4);
      end
    end
    cycle(acc, tk, td, st);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_end actual=%b expected=0", out_valid);
    end
  endtask

  task automatic test_stall();
    bit acc, tk, st;
    logic [6:0] td;
    int takes;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'h91;
    cycle(acc, tk, td, st);
    in_word = 8'h03;
    cycle(acc, tk, td, st);
    in_valid = 1'b0;
    takes = 0;
    for (int n = 0; n < 20; n++) begin
      out_ready = (n % 2 == 0);
      cycle(acc, tk, td, st);
      if (tk) begin
        takes++;
        checks++;
        if (td !== 7'h11) begin
          failures++;
          $display("FAIL stall_take actual=%h expected=11", td);
        end
      end
      if (st) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== td) begin
          failures++;
          $display("FAIL stall_hold actual=v%b d%h expected=v1 d%h", out_valid, out_data, td);
        end
      end
    end
    checks++;
    if (takes != 3) begin
      failures++;
      $display("FAIL stall_count actual=%0d expected=3", takes);
    end
  endtask

  task automatic test_zero_run();
    bit acc, tk, st;
    logic [6:0] td;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'h85;
    cycle(acc, tk, td, st);
    in_word = 8'h00;
    cycle(acc, tk, td, st);
    checks++;
    if (err_zero_run !== 1'b1 || run_active !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_run actual=err%b ra%b v%b expected=err1 ra0 v0", err_zero_run, run_active, out_valid);
    end
    in_word = 8'h06;
    cycle(acc, tk, td, st);
    in_valid = 1'b0;
    checks++;
    if (!acc || out_valid !== 1'b1 || out_data !== 7'h06 || err_zero_run !== 1'b1) begin
      failures++;
      $display("FAIL zero_run_next actual=acc%b v%b d%h err%b expected=acc1 v1 d06 err1",
               acc, out_valid, out_data, err_zero_run);
    end
  endtask

  task automatic test_long_run();
    bit acc, tk, st;
    logic [6:0] td;
    logic [6:0] sym;
    int copies, bad;
    sym       = 7'($urandom_range(0, 127));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = {1'b1, sym};
    cycle(acc, tk, td, st);
    in_word = 8'hFF;
    cycle(acc, tk, td, st);
    in_valid = 1'b0;
    copies = 0;
    bad    = 0;
    for (int n = 0; n < 300; n++) begin
      cycle(acc, tk, td, st);
      if (out_valid === 1'b1) begin
        copies++;
        if (out_data !== sym) bad++;
      end
      if (run_active !== 1'b1) break;
    end
    checks++;
    if (copies != 255 || bad != 0) begin
      failures++;
      $display("FAIL long_run actual=copies%0d bad%0d expected=copies255 bad0", copies, bad);
    end
    cycle(acc, tk, td, st);
    checks++;
    if (out_valid !== 1'b0 || run_active !== 1'b0) begin
      failures++;
      $display("FAIL long_run_end actual=v%b ra%b expected=v0 ra0", out_valid, run_active);
    end
  endtask

  task automatic test_reset_mid_run();
    bit acc, tk, st;
    logic [6:0] td;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'hC4;
    cycle(acc, tk, td, st);
    in_word = 8'h14;
    cycle(acc, tk, td, st);
    in_valid = 1'b0;
    repeat (10) cycle(acc, tk, td, st);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || run_active !== 1'b0 || out_data !== 7'h00 || err_zero_run !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run actual=v%b ra%b d%h err%b expected=v0 ra0 d00 err0",
               out_valid, run_active, out_data, err_zero_run);
    end
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_word  = 8'h2A;
    cycle(acc, tk, td, st);
    in_valid = 1'b0;
    checks++;
    if (!acc || out_valid !== 1'b1 || out_data !== 7'h2A) begin
      failures++;
      $display("FAIL after_reset_literal actual=acc%b v%b d%h expected=acc1 v1 d2A", acc, out_valid, out_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] stream [$];
    logic [6:0] expq [$];
    logic [6:0] sym, exp_sym;
    logic [7:0] cnt;
    bit exp_err;
    bit acc, tk, st;
    logic [6:0] td;
    int idx, cyc;
    do_reset();
    exp_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sym = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) begin
        stream.push_back({1'b0, sym});
        expq.push_back(sym);
      end else begin
        cnt = 8'($urandom_range(0, 6));
        stream.push_back({1'b1, sym});
        stream.push_back(cnt);
        if (cnt == 0) exp_err = 1'b1;
        for (int c = 0; c < int'(cnt); c++) expq.push_back(sym);
      end
    end
    idx = 0;
    cyc = 0;
    while ((idx < stream.size() || expq.size() != 0) && cyc < 4000) begin
      in_valid  = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
      in_word   = (idx < stream.size()) ? stream[idx] : 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc, tk, td, st);
      cyc++;
      if (acc) idx++;
      if (tk) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL random_extra actual=%h expected=none", td);
        end else begin
          exp_sym = expq.pop_front();
          if (td !== exp_sym) begin
            failures++;
            $display("FAIL random_data actual=%h expected=%h", td, exp_sym);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (expq.size() != 0 || idx != stream.size()) begin
      failures++;
      $display("FAIL random_done actual=left%0d idx%0d expected=left0 idx%0d", expq.size(), idx, stream.size());
    end
    checks++;
    if (err_zero_run !== exp_err) begin
      failures++;
      $display("FAIL random_err actual=%b expected=%b", err_zero_run, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_run();
    test_stall();
    test_zero_run();
    test_long_run();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
